// File: rtl/fractal_sync_pkg.sv
// Shared types and helpers for the fractal synchronization arbiter.
package fractal_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAKE  = 2'd2,
    LERR  = 2'd3
  } arb_state_e;

  function automatic logic level_legal(input logic [31:0] level, input logic [31:0] max_level);
    return (level != 32'd0) && (level <= max_level);
  endfunction

endpackage

// File: rtl/fractal_rr_picker.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo N_REQ.
module fractal_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Walk offsets from farthest to nearest so the nearest candidate wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      logic [IDX_W-1:0] cand;
      cand    = IDX_W'((int'(ptr_i) + i) % N_REQ);
      valid_o = valid_o | req_i[cand];
      idx_o   = req_i[cand] ? cand : idx_o;
    end
  end

endmodule

// File: rtl/fractal_sync_arbiter.sv
// Shares one upward fractal sync port among N_REQ local requesters, round-robin,
// rejecting illegal levels locally.
module fractal_sync_arbiter
  import fractal_sync_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int LVL_WIDTH = 3,
  parameter int MAX_LEVEL = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_sync_i,
  input  logic [N_REQ*LVL_WIDTH-1:0] req_level_i,
  output logic [N_REQ-1:0]           req_wake_o,
  output logic [N_REQ-1:0]           req_error_o,
  input  logic [N_REQ-1:0]           req_ack_i,
  output logic                       sync_o,
  output logic [LVL_WIDTH-1:0]       level_o,
  input  logic                       wake_i,
  input  logic                       error_i,
  output logic                       ack_o,
  output logic [N_REQ-1:0]           grant_o,
  output logic [CNT_WIDTH-1:0]       grant_cnt_o,
  output logic [CNT_WIDTH-1:0]       lvl_err_cnt_o,
  output logic [CNT_WIDTH-1:0]       spurious_cnt_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d, ptr_q, ptr_d;
  logic [N_REQ-1:0]     grant_q, grant_d, wake_q, wake_d, err_q, err_d;
  logic                 sync_q, sync_d;
  logic [LVL_WIDTH-1:0] level_q, level_d;
  logic [CNT_WIDTH-1:0] grant_cnt_q, grant_cnt_d;
  logic [CNT_WIDTH-1:0] lvl_err_cnt_q, lvl_err_cnt_d;
  logic [CNT_WIDTH-1:0] spurious_cnt_q, spurious_cnt_d;

  logic                 pick_valid_s;
  logic [IDX_W-1:0]     pick_idx_s, next_ptr_s;
  logic [LVL_WIDTH-1:0] pick_lvl_s;
  logic                 gnt_ack_s;

  fractal_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (req_sync_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid_s),
    .idx_o   (pick_idx_s)
  );

  assign pick_lvl_s = req_level_i[int'(pick_idx_s)*LVL_WIDTH +: LVL_WIDTH];
  assign next_ptr_s = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
  assign gnt_ack_s  = req_ack_i[idx_q];

  // Next-state and next-output logic for the grant/issue/wake handshake.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    ptr_d          = ptr_q;
    grant_d        = grant_q;
    wake_d         = wake_q;
    err_d          = err_q;
    sync_d         = sync_q;
    level_d        = level_q;
    grant_cnt_d    = grant_cnt_q;
    lvl_err_cnt_d  = lvl_err_cnt_q;
    spurious_cnt_d = spurious_cnt_q;
    case (state_q)
      IDLE: begin
        if (wake_i) begin
          spurious_cnt_d = (spurious_cnt_q == CNT_MAX) ? spurious_cnt_q : spurious_cnt_q + CNT_WIDTH'(1);
        end else begin
          spurious_cnt_d = spurious_cnt_q;
        end
        if (pick_valid_s) begin
          idx_d   = pick_idx_s;
          grant_d = N_REQ'(1) << pick_idx_s;
          if (level_legal(32'(pick_lvl_s), 32'(MAX_LEVEL))) begin
            sync_d  = 1'b1;
            level_d = pick_lvl_s;
            state_d = ISSUE;
          end else begin
            state_d = LERR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (wake_i) begin
          sync_d  = 1'b0;
          level_d = '0;
          wake_d  = grant_q;
          err_d   = error_i ? grant_q : '0;
          state_d = WAKE;
        end else begin
          state_d = ISSUE;
        end
      end
      WAKE: begin
        if (gnt_ack_s) begin
          wake_d      = '0;
          err_d       = '0;
          grant_d     = '0;
          ptr_d       = next_ptr_s;
          grant_cnt_d = (grant_cnt_q == CNT_MAX) ? grant_cnt_q : grant_cnt_q + CNT_WIDTH'(1);
          state_d     = IDLE;
        end else begin
          state_d = WAKE;
        end
      end
      LERR: begin
        // First LERR cycle raises wake/error; ack is honoured only once wake is visible.
        if (!wake_q[idx_q]) begin
          wake_d = grant_q;
          err_d  = grant_q;
        end else if (gnt_ack_s) begin
          wake_d        = '0;
          err_d         = '0;
          grant_d       = '0;
          ptr_d         = next_ptr_s;
          lvl_err_cnt_d = (lvl_err_cnt_q == CNT_MAX) ? lvl_err_cnt_q : lvl_err_cnt_q + CNT_WIDTH'(1);
          state_d       = IDLE;
        end else begin
          state_d = LERR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      ptr_q          <= '0;
      grant_q        <= '0;
      wake_q         <= '0;
      err_q          <= '0;
      sync_q         <= 1'b0;
      level_q        <= '0;
      grant_cnt_q    <= '0;
      lvl_err_cnt_q  <= '0;
      spurious_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      ptr_q          <= ptr_d;
      grant_q        <= grant_d;
      wake_q         <= wake_d;
      err_q          <= err_d;
      sync_q         <= sync_d;
      level_q        <= level_d;
      grant_cnt_q    <= grant_cnt_d;
      lvl_err_cnt_q  <= lvl_err_cnt_d;
      spurious_cnt_q <= spurious_cnt_d;
    end
  end

  assign ack_o          = (state_q == WAKE) ? gnt_ack_s : 1'b0;
  assign req_wake_o     = wake_q;
  assign req_error_o    = err_q;
  assign sync_o         = sync_q;
  assign level_o        = level_q;
  assign grant_o        = grant_q;
  assign grant_cnt_o    = grant_cnt_q;
  assign lvl_err_cnt_o  = lvl_err_cnt_q;
  assign spurious_cnt_o = spurious_cnt_q;

endmodule

// File: doc/fractal_sync_arbiter.md
Name: fractal_sync_arbiter

Overview:
Shares one upward fractal synchronization port among N_REQ local requesters, e.g. several cores inside one CU that sit behind a single CU-level fractal_sync slave port.
- Grants one requester at a time, round-robin.
- Forwards the granted requester's sync/level upstream and returns wake/error to it.
- Completes the wake/ack handshake before the next grant.
- Rejects illegal levels locally, without going upstream.

Parameters:
N_REQ, 4, number of local requesters (>=2)
LVL_WIDTH, 3, width of the level field (matches CU-level port width)
MAX_LEVEL, 2, highest legal sync level; legal range is 1..MAX_LEVEL
CNT_WIDTH, 16, width of the statistics counters

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_sync_i  in  N_REQ  per-requester sync request (level, held until wake)
req_level_i  in  N_REQ*LVL_WIDTH  per-requester sync level
req_wake_o  out  N_REQ  per-requester wake
req_error_o  out  N_REQ  per-requester error, valid while wake is high
req_ack_i  in  N_REQ  per-requester acknowledge of wake
sync_o  out  1  upstream sync
level_o  out  LVL_WIDTH  upstream level
wake_i  in  1  upstream wake
error_i  in  1  upstream error
ack_o  out  1  upstream acknowledge
grant_o  out  N_REQ  one-hot current grant, 0 in IDLE
grant_cnt_o  out  CNT_WIDTH  completed upstream syncs, saturating
lvl_err_cnt_o  out  CNT_WIDTH  locally rejected requests, saturating
spurious_cnt_o  out  CNT_WIDTH  wake_i seen in IDLE, saturating

Behaviour:
Reset:
- Active when rst_i is sampled high.
- All outputs go to 0, FSM to IDLE, round-robin pointer to 0, counters to 0.
- Reset mid-transaction aborts it; no wake is delivered.

FSM states: IDLE, ISSUE, WAKE, LERR.

IDLE:
- If any req_sync_i is high, pick the first set bit starting at pointer and wrapping modulo N_REQ.
- Latch the index and its req_level_i, and drive grant_o one-hot from the next cycle.
- If the level is 0 or greater than MAX_LEVEL, go to LERR. Otherwise go to ISSUE.
- wake_i seen in IDLE: ignored, and spurious_cnt_o increments.

ISSUE:
- sync_o=1 and level_o=latched level, registered, so first high one cycle after the request is sampled.
- Held until wake_i is sampled high. Then sync_o=0 next cycle, error_i is latched, and the FSM goes to WAKE.
- No timeout.

WAKE:
- req_wake_o[g]=1 and req_error_o[g]=latched error, registered, so one cycle after wake_i is sampled.
- ack_o = req_ack_i[g], combinational pass-through, only in WAKE.
- When req_ack_i[g] is sampled high:
  - drop wake/error next cycle;
  - increment grant_cnt_o;
  - set pointer = (g+1) mod N_REQ;
  - return to IDLE.
- Upstream wake_i/error_i changes during WAKE are ignored; values stay latched.

LERR:
- req_wake_o[g]=1 and req_error_o[g]=1, with no upstream activity (sync_o and ack_o stay 0).
- On req_ack_i[g]: increment lvl_err_cnt_o, advance the pointer, return to IDLE.

General rules:
- Minimum turnaround IDLE to IDLE is 4 cycles when wake and ack each return in 1 cycle.
- Non-granted requesters see wake=0 and error=0 throughout.
- req_sync_i dropped by the grantee after the grant does not cancel the transaction.
- Simultaneous requests are resolved round-robin only; no priority input.
- Requester index N_REQ-1 wraps to 0.
- Counters saturate at all-ones.
- req_ack_i on a non-granted requester is ignored.

Decomposition:
- Shared package fractal_sync_pkg holds:
  - arb_state_e enum (IDLE, ISSUE, WAKE, LERR);
  - level-legality function taking level and MAX_LEVEL.
- One sub-module: fractal_rr_picker, combinational. Inputs: request vector and pointer. Outputs: valid and index (first set bit from pointer, wrapping).
- Counters and FSM stay in the top module.

Test Plan:
- Single requester 2 issues level 1; upstream returns wake with error=0 after 3 cycles; requester acks after 2 cycles. Required:
  - sync_o rises 1 cycle after the request, level_o=1;
  - req_wake_o[2]=1, req_error_o=0;
  - ack_o coincides with req_ack_i[2];
  - grant_cnt_o=1 and pointer=3 afterwards.
- All 4 requesters request simultaneously from reset, with upstream always answering. Required: grant order 0,1,2,3; grant_cnt_o=4; no two bits of grant_o ever set at once.
- Requester 1 issues level 0, then level 3 (MAX_LEVEL=2). Required:
  - each gets wake=1, error=1 one cycle after grant;
  - sync_o stays 0;
  - lvl_err_cnt_o=2.
- Upstream returns error_i=1, then drops error_i during WAKE. Required: req_error_o stays 1 until ack.
- wake_i pulsed high for 1 cycle in IDLE. Required: no req_wake_o activity; spurious_cnt_o=1.
- rst_i asserted 1 cycle while in WAKE. Required: next cycle all outputs 0, state IDLE, counters 0; a fresh request from requester 0 is then served normally.
